// File: rtl/atm_terminal_seq.sv
// Terminal-side sequencer: card present, serial PIN digits, amount strobe, then result classification.
// Outputs are driven from registered state only; cajero flags are sampled level-sensitively.
module atm_terminal_seq #(
   parameter int CARD_CYC = 2,
   parameter int GAP_CYC  = 2,
   parameter int PIN_WAIT = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] PIN_in,
   input  logic        Tipo_in,
   input  logic [31:0] Monto_in,
   input  logic        Balance_actualizado,
   input  logic        Entregar_dinero,
   input  logic        Fondos_insuficientes,
   input  logic        PIN_incorrecto,
   input  logic        Advertencia,
   input  logic        Bloqueo,
   output logic        Tarjeta_recibida,
   output logic [3:0]  Digito,
   output logic        Digito_STB,
   output logic        Tipo_trans,
   output logic [31:0] Monto,
   output logic        Monto_STB,
   output logic        Busy,
   output logic        Done,
   output logic [2:0]  Resultado
);

   localparam int CW = $clog2(CARD_CYC + GAP_CYC + PIN_WAIT + TIMEOUT + 1) + 1;

   localparam logic [CW-1:0] CARD_LAST = CW'(CARD_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] PW_LAST   = CW'(PIN_WAIT - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

   localparam logic [2:0] RES_NONE    = 3'd0;
   localparam logic [2:0] RES_DEP_OK  = 3'd1;
   localparam logic [2:0] RES_RET_OK  = 3'd2;
   localparam logic [2:0] RES_FONDOS  = 3'd3;
   localparam logic [2:0] RES_PIN_ERR = 3'd4;
   localparam logic [2:0] RES_ADVERT  = 3'd5;
   localparam logic [2:0] RES_BLOQUEO = 3'd6;
   localparam logic [2:0] RES_TIMEOUT = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CARD,
      S_DIGIT,
      S_GAP,
      S_PIN_CHK,
      S_AMOUNT,
      S_RESULT,
      S_DONE
   } state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt;
   logic [1:0]     idx, idx_n;
   logic [15:0]    pin_l;
   logic           tipo_l;
   logic [31:0]    monto_l;
   logic [3:0]     digito_r;
   logic           tipo_r;
   logic [31:0]    monto_r;
   logic [2:0]     res_r, res_n;
   logic [2:0]     pin_code, txn_code;

   function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] i);
      case (i)
         2'd0:    nibble = v[15:12];
         2'd1:    nibble = v[11:8];
         2'd2:    nibble = v[7:4];
         default: nibble = v[3:0];
      endcase
   endfunction

   // Error flags that can end the PIN phase early.
   always_comb begin
      pin_code = RES_NONE;
      if (Bloqueo)             pin_code = RES_BLOQUEO;
      else if (Advertencia)    pin_code = RES_ADVERT;
      else if (PIN_incorrecto) pin_code = RES_PIN_ERR;
   end

   // Transaction outcome; success flags only count when they match the latched type.
   always_comb begin
      txn_code = pin_code;
      if (pin_code == RES_NONE) begin
         if (Fondos_insuficientes)           txn_code = RES_FONDOS;
         else if (Entregar_dinero && tipo_l) txn_code = RES_RET_OK;
         else if (Balance_actualizado && !tipo_l) txn_code = RES_DEP_OK;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      res_n   = RES_NONE;
      case (state)
         S_IDLE: begin
            if (Start) begin
               state_n = S_CARD;
               idx_n   = 2'd0;
            end
         end
         S_CARD: begin
            if (cnt == CARD_LAST) state_n = S_DIGIT;
         end
         S_DIGIT: begin
            if (pin_code != RES_NONE) begin
               state_n = S_DONE;
               res_n   = pin_code;
            end else if (idx == 2'd3) begin
               state_n = S_PIN_CHK;
            end else begin
               state_n = S_GAP;
            end
         end
         S_GAP: begin
            if (pin_code != RES_NONE) begin
               state_n = S_DONE;
               res_n   = pin_code;
            end else if (cnt == GAP_LAST) begin
               state_n = S_DIGIT;
               idx_n   = idx + 2'd1;
            end
         end
         S_PIN_CHK: begin
            if (pin_code != RES_NONE) begin
               state_n = S_DONE;
               res_n   = pin_code;
            end else if (cnt == PW_LAST) begin
               state_n = S_AMOUNT;
            end
         end
         S_AMOUNT: begin
            state_n = S_RESULT;
         end
         S_RESULT: begin
            if (txn_code != RES_NONE) begin
               state_n = S_DONE;
               res_n   = txn_code;
            end else if (cnt == TO_LAST) begin
               state_n = S_DONE;
               res_n   = RES_TIMEOUT;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= 2'd0;
         pin_l    <= 16'd0;
         tipo_l   <= 1'b0;
         monto_l  <= 32'd0;
         digito_r <= 4'd0;
         tipo_r   <= 1'b0;
         monto_r  <= 32'd0;
         res_r    <= RES_NONE;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         // Per-state dwell counter; restarts on every state change and saturates.
         if (state_n != state)  cnt <= '0;
         else if (cnt != '1)    cnt <= cnt + 1'b1;

         if (state == S_IDLE && Start) begin
            pin_l   <= PIN_in;
            tipo_l  <= Tipo_in;
            monto_l <= Monto_in;
            res_r   <= RES_NONE;
         end
         if (state_n == S_DIGIT && state != S_DIGIT) digito_r <= nibble(pin_l, idx_n);
         if (state_n == S_AMOUNT) begin
            tipo_r  <= tipo_l;
            monto_r <= monto_l;
         end
         if (state_n == S_DONE && state != S_DONE) begin
            digito_r <= 4'd0;
            tipo_r   <= 1'b0;
            monto_r  <= 32'd0;
            res_r    <= res_n;
         end
      end
   end

   assign Tarjeta_recibida = (state != S_IDLE) && (state != S_DONE);
   assign Busy             = (state != S_IDLE) && (state != S_DONE);
   assign Digito_STB       = (state == S_DIGIT);
   assign Monto_STB        = (state == S_AMOUNT);
   assign Done             = (state == S_DONE);
   assign Digito           = digito_r;
   assign Tipo_trans       = tipo_r;
   assign Monto            = monto_r;
   assign Resultado        = res_r;

endmodule

// File: tb/tb_atm_terminal_seq.sv
// Bench for atm_terminal_seq: table of transactions, expected strobes/results queued at stimulus time.
module tb_atm_terminal_seq;

   localparam int CARD = 2;
   localparam int GAP  = 2;
   localparam int PW   = 4;
   localparam int TO   = 64;

   localparam int EV_DIG  = 0;
   localparam int EV_MON  = 1;
   localparam int EV_DONE = 2;

   // flag bit order: {Bloqueo, Advertencia, PIN_incorrecto, Fondos, Entregar, Balance}
   localparam logic [5:0] F_BAL = 6'b000001;
   localparam logic [5:0] F_ENT = 6'b000010;
   localparam logic [5:0] F_FON = 6'b000100;
   localparam logic [5:0] F_PIN = 6'b001000;
   localparam logic [5:0] F_ADV = 6'b010000;
   localparam logic [5:0] F_BLQ = 6'b100000;

   logic        CLK = 1'b0;
   logic        Reset, Start, Tipo_in;
   logic [15:0] PIN_in;
   logic [31:0] Monto_in;
   logic [5:0]  flags;
   logic        Tarjeta_recibida, Digito_STB, Tipo_trans, Monto_STB, Busy, Done;
   logic [3:0]  Digito;
   logic [31:0] Monto;
   logic [2:0]  Resultado;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      int          kind;
      logic [31:0] val;
      logic        aux;
      int          cyc;
   } ev_t;

   typedef struct {
      logic [15:0] pin;
      logic        tipo;
      logic [31:0] monto;
      logic [5:0]  fl;
      int          phase;   // 0: delay from last digit strobe, 1: delay from Monto_STB
      int          dly;
      int          sdly;    // nonzero: stray Start this many cycles after Monto_STB
      logic [2:0]  exp_res;
   } txn_t;

   ev_t  exp_q[$];
   txn_t tbl[10];

   atm_terminal_seq dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .PIN_in(PIN_in), .Tipo_in(Tipo_in),
      .Monto_in(Monto_in),
      .Balance_actualizado(flags[0]), .Entregar_dinero(flags[1]),
      .Fondos_insuficientes(flags[2]), .PIN_incorrecto(flags[3]),
      .Advertencia(flags[4]), .Bloqueo(flags[5]),
      .Tarjeta_recibida(Tarjeta_recibida), .Digito(Digito), .Digito_STB(Digito_STB),
      .Tipo_trans(Tipo_trans), .Monto(Monto), .Monto_STB(Monto_STB),
      .Busy(Busy), .Done(Done), .Resultado(Resultado)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] val, input logic aux, input int c);
      ev_t e;
      e.kind = kind; e.val = val; e.aux = aux; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic take(input int kind, input logic [31:0] val, input logic aux);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_event: kind %0d value %0h with nothing expected (cycle %0d)",
                  kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_value", val, e.val);
         chk("event_cycle", cyc, e.cyc);
         if (kind == EV_MON) chk("tipo_trans", {31'd0, aux}, {31'd0, e.aux});
      end
   endtask

   always @(negedge CLK) begin
      if (!Reset) begin
         if (Digito_STB) take(EV_DIG, {28'd0, Digito}, 1'b0);
         if (Monto_STB)  take(EV_MON, Monto, Tipo_trans);
         if (Done)       take(EV_DONE, {29'd0, Resultado}, 1'b0);
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_tarjeta"}, {31'd0, Tarjeta_recibida}, 32'd0);
      chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
      chk({tag, "_digito_stb"}, {31'd0, Digito_STB}, 32'd0);
      chk({tag, "_monto_stb"}, {31'd0, Monto_STB}, 32'd0);
      chk({tag, "_digito"}, {28'd0, Digito}, 32'd0);
      chk({tag, "_monto"}, Monto, 32'd0);
      chk({tag, "_tipo"}, {31'd0, Tipo_trans}, 32'd0);
   endtask

   function automatic logic [3:0] nib(input logic [15:0] p, input int i);
      logic [15:0] s;
      s = p >> (4 * (3 - i));
      return s[3:0];
   endfunction

   task automatic run_txn(input txn_t t);
      int s, d3, a, fc, dc;
      @(negedge CLK);
      PIN_in = t.pin; Tipo_in = t.tipo; Monto_in = t.monto; Start = 1'b1;
      s  = cyc;
      d3 = s + 1 + CARD + 3 * (GAP + 1);
      a  = d3 + PW + 1;
      fc = (t.phase == 0 ? d3 : a) + t.dly;
      for (int i = 0; i < 4; i++) begin
         if (t.phase == 1 || (s + 1 + CARD + i * (GAP + 1)) <= fc)
            push(EV_DIG, {28'd0, nib(t.pin, i)}, 1'b0, s + 1 + CARD + i * (GAP + 1));
      end
      if (t.phase == 1) push(EV_MON, t.monto, t.tipo, a);
      dc = (t.exp_res == 3'd7) ? a + TO + 1 : fc + 1;
      push(EV_DONE, {29'd0, t.exp_res}, 1'b0, dc);
      @(negedge CLK);
      Start = 1'b0;
      PIN_in = ~t.pin; Tipo_in = ~t.tipo; Monto_in = ~t.monto;
      chk("busy_after_start", {31'd0, Busy}, 32'd1);
      chk("tarjeta_after_start", {31'd0, Tarjeta_recibida}, 32'd1);
      while (cyc < dc) begin
         flags = (cyc == fc) ? t.fl : 6'd0;
         Start = (t.sdly != 0 && cyc == a + t.sdly);
         @(negedge CLK);
      end
      flags = 6'd0;
      Start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("resultado_hold", {29'd0, Resultado}, {29'd0, t.exp_res});
         chk("done_cleared", {31'd0, Done}, 32'd0);
         check_idle_outputs("post_done");
      end
   endtask

   initial begin
      int s, gc;
      tbl[0] = '{16'h1234, 1'b1, 32'd500,         F_ENT,         1,  3, 0, 3'd2};
      tbl[1] = '{16'h9870, 1'b0, 32'hFFFF_FFFF,   F_BAL,         1,  5, 0, 3'd1};
      tbl[2] = '{16'h5555, 1'b0, 32'd100,         F_ENT,         1,  3, 0, 3'd7};
      tbl[3] = '{16'h4321, 1'b1, 32'd20,          F_PIN,         0,  2, 0, 3'd4};
      tbl[4] = '{16'h1111, 1'b1, 32'd30,          F_BLQ | F_ADV, 0,  1, 0, 3'd6};
      tbl[5] = '{16'h2468, 1'b1, 32'd1000,        F_FON | F_ENT, 1,  2, 0, 3'd3};
      tbl[6] = '{16'h1357, 1'b1, 32'd77,          F_ENT,         1, 10, 3, 3'd2};
      tbl[7] = '{16'h8642, 1'b1, 32'd55,          F_ADV,         0, -2, 0, 3'd5};
      tbl[8] = '{16'h0909, 1'b0, 32'h8000_0001,   F_PIN,         1,  1, 0, 3'd4};
      tbl[9] = '{16'h7777, 1'b1, 32'd12,          F_BAL,         1,  2, 0, 3'd7};

      Reset = 1'b1; Start = 1'b0; PIN_in = 16'd0; Tipo_in = 1'b0; Monto_in = 32'd0; flags = 6'd0;
      repeat (3) @(negedge CLK);
      Reset = 1'b0;
      @(negedge CLK);
      check_idle_outputs("reset");
      chk("reset_done", {31'd0, Done}, 32'd0);
      chk("reset_resultado", {29'd0, Resultado}, 32'd0);

      // Reset in the gap after the second digit, then a clean transaction follows.
      @(negedge CLK);
      PIN_in = 16'h9753; Tipo_in = 1'b1; Monto_in = 32'd9; Start = 1'b1;
      s = cyc;
      push(EV_DIG, 32'd9, 1'b0, s + 1 + CARD);
      push(EV_DIG, 32'd7, 1'b0, s + 1 + CARD + GAP + 1);
      @(negedge CLK);
      Start = 1'b0;
      gc = 0;
      while (cyc < s + 1 + CARD + GAP + 2 && gc < 100) begin
         @(negedge CLK);
         gc++;
      end
      chk("reach_gap", {31'd0, (cyc == s + 1 + CARD + GAP + 2)}, 32'd1);
      Reset = 1'b1;
      @(negedge CLK);
      check_idle_outputs("midgap_reset");
      chk("midgap_resultado", {29'd0, Resultado}, 32'd0);
      Reset = 1'b0;

      for (int i = 0; i < 10; i++) run_txn(tbl[i]);

      repeat (5) @(negedge CLK);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
